// File: rtl/seq_detect_moore_param_if.sv
// Serial-stream bundle for the programmable sequence detector: bit/enable,
// pattern-load controls and the registered match outputs.
interface seq_detect_moore_param_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LW      = $clog2(MAX_LEN + 1)
);
  logic               en;
  logic               din;
  logic               overlap;
  logic               load;
  logic [MAX_LEN-1:0] load_pattern;
  logic [LW-1:0]      load_len;
  logic               dout;
  logic [CNT_W-1:0]   match_count;

  modport master (
    output en, din, overlap, load, load_pattern, load_len,
    input  dout, match_count
  );

  modport slave (
    input  en, din, overlap, load, load_pattern, load_len,
    output dout, match_count
  );
endinterface

// File: rtl/seq_detect_moore_param.sv
// Runtime-programmable Moore sequence detector with overlap select, enable
// qualification and a saturating match counter.
module seq_detect_moore_param #(
  parameter int                 MAX_LEN         = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(8'b0000_1101),
  parameter int                 DEFAULT_LEN     = 4,
  parameter int                 CNT_W           = 8,
  parameter int                 LW              = $clog2(MAX_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  seq_detect_moore_param_if.slave  bus
);

  logic [MAX_LEN-1:0] r_hist, w_hist_nxt;
  logic [LW-1:0]      r_fill, w_fill_nxt;
  logic [MAX_LEN-1:0] r_pat,  w_pat_nxt;
  logic [LW-1:0]      r_len,  w_len_nxt;
  logic               r_dout, w_dout_nxt;
  logic [CNT_W-1:0]   r_cnt,  w_cnt_nxt;

  logic [MAX_LEN-1:0] w_newhist;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_full;
  logic               w_eq;
  logic               w_hit;
  logic               w_load_ok;
  logic [LW-1:0]      w_fill_inc;
  logic [CNT_W-1:0]   w_cnt_inc;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist <= '0;
      r_fill <= '0;
      r_pat  <= DEFAULT_PATTERN;
      r_len  <= LW'(DEFAULT_LEN);
      r_dout <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_hist <= w_hist_nxt;
      r_fill <= w_fill_nxt;
      r_pat  <= w_pat_nxt;
      r_len  <= w_len_nxt;
      r_dout <= w_dout_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  // Only the low len bits of history take part in the compare.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++)
      w_mask[i] = (i < int'(r_len));
  end

  assign w_newhist  = {r_hist[MAX_LEN-2:0], bus.din};
  assign w_full     = ({1'b0, r_fill} + (LW+1)'(1)) >= {1'b0, r_len};
  assign w_eq       = ((w_newhist ^ r_pat) & w_mask) == '0;
  assign w_hit      = w_full & w_eq;
  assign w_load_ok  = (bus.load_len != '0) && (bus.load_len <= LW'(MAX_LEN));
  assign w_fill_inc = (r_fill == LW'(MAX_LEN)) ? r_fill : r_fill + LW'(1);
  assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

  // Next-state: load beats en; an illegal load is dropped entirely.
  always_comb begin
    w_hist_nxt = r_hist;
    w_fill_nxt = r_fill;
    w_pat_nxt  = r_pat;
    w_len_nxt  = r_len;
    w_dout_nxt = r_dout;
    w_cnt_nxt  = r_cnt;
    if (bus.load) begin
      if (w_load_ok) begin
        w_pat_nxt  = bus.load_pattern;
        w_len_nxt  = bus.load_len;
        w_hist_nxt = '0;
        w_fill_nxt = '0;
        w_dout_nxt = 1'b0;
      end
    end else if (bus.en) begin
      w_hist_nxt = w_newhist;
      w_dout_nxt = w_hit;
      if (w_hit) begin
        w_cnt_nxt  = w_cnt_inc;
        w_fill_nxt = bus.overlap ? w_fill_inc : '0;
      end else begin
        w_fill_nxt = w_fill_inc;
      end
    end
  end

  // Outputs are pure register taps (Moore).
  always_comb begin
    bus.dout        = r_dout;
    bus.match_count = r_cnt;
  end

endmodule
